// File: rtl/lock_password_setter_if.sv
// Key stream in, stored password / display / status out for the lock's password setter.
interface lock_password_setter_if;
    logic        set_request;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] stored_pw;
    logic [15:0] entry_digits;
    logic [1:0]  mode;
    logic        set_done;
    logic        set_error;
    logic        clear_lockout;

    modport master (
        output set_request, key_valid, key_code,
        input  stored_pw, entry_digits, mode, set_done, set_error, clear_lockout
    );

    modport slave (
        input  set_request, key_valid, key_code,
        output stored_pw, entry_digits, mode, set_done, set_error, clear_lockout
    );
endinterface

// File: rtl/lock_password_setter.sv
// Password programming path of the keypad lock: authenticate with the current
// password, type the new one, confirm it, then commit and release the lockout.
module lock_password_setter #(
    parameter logic [15:0] DEFAULT_PW     = 16'h1234,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    lock_password_setter_if.slave  bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    // Abort on the idle cycle that would carry the counter to TIMEOUT_CYCLES-1.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_AUTH    = 2'd1,
        ST_NEW     = 2'd2,
        ST_CONFIRM = 2'd3
    } state_t;

    function automatic logic [15:0] put_nibble(input logic [15:0] word,
                                               input logic [1:0]  idx,
                                               input logic [3:0]  val);
        logic [15:0] res;
        res = word;
        case (idx)
            2'd0:    res[15:12] = val;
            2'd1:    res[11:8]  = val;
            2'd2:    res[7:4]   = val;
            2'd3:    res[3:0]   = val;
            default: res        = word;
        endcase
        return res;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [15:0]       entry_r, entry_nxt_s;
    logic [2:0]        count_r, count_nxt_s;
    logic [15:0]       buf_r, buf_nxt_s;
    logic [15:0]       stored_r, stored_nxt_s;
    logic [TMR_W-1:0]  tmr_r, tmr_nxt_s;
    logic              done_r, done_nxt_s;
    logic              error_r, error_nxt_s;
    logic              clear_lockout_r;
    logic              prev_req_r;

    logic              set_edge_s;
    logic              key_accept_s;
    logic              key_digit_s;
    logic              key_delete_s;
    logic [1:0]        del_idx_s;

    assign set_edge_s   = bus.set_request & ~prev_req_r;
    assign key_digit_s  = (bus.key_code >= 4'd1) && (bus.key_code <= 4'd9);
    assign key_delete_s = (bus.key_code == 4'd10);
    assign key_accept_s = bus.key_valid && (bus.key_code >= 4'd1) && (bus.key_code <= 4'd11);
    assign del_idx_s    = count_r[1:0] - 2'd1;

    // Next-state, entry editing, evaluation and timeout decisions.
    always_comb begin
        state_nxt_s  = state_r;
        entry_nxt_s  = entry_r;
        count_nxt_s  = count_r;
        buf_nxt_s    = buf_r;
        stored_nxt_s = stored_r;
        tmr_nxt_s    = tmr_r;
        done_nxt_s   = 1'b0;
        error_nxt_s  = 1'b0;

        if (state_r == ST_IDLE) begin
            tmr_nxt_s = TMR_ZERO;
            if (set_edge_s) begin
                state_nxt_s = ST_AUTH;
                entry_nxt_s = 16'h0000;
                count_nxt_s = 3'd0;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (count_r == 3'd4) begin
            // A full entry is judged one cycle after its last digit; keys are dropped here.
            entry_nxt_s = 16'h0000;
            count_nxt_s = 3'd0;
            tmr_nxt_s   = TMR_ZERO;
            case (state_r)
                ST_AUTH: begin
                    if (entry_r == stored_r) begin
                        state_nxt_s = ST_NEW;
                    end else begin
                        error_nxt_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_NEW: begin
                    buf_nxt_s   = entry_r;
                    state_nxt_s = ST_CONFIRM;
                end
                ST_CONFIRM: begin
                    buf_nxt_s = 16'h0000;
                    if (entry_r == buf_r) begin
                        stored_nxt_s = buf_r;
                        done_nxt_s   = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        error_nxt_s  = 1'b1;
                        state_nxt_s  = ST_NEW;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (key_accept_s) begin
            tmr_nxt_s = TMR_ZERO;
            if (key_digit_s) begin
                entry_nxt_s = put_nibble(entry_r, count_r[1:0], bus.key_code);
                count_nxt_s = count_r + 3'd1;
            end else if (key_delete_s) begin
                if (count_r != 3'd0) begin
                    entry_nxt_s = put_nibble(entry_r, del_idx_s, 4'd0);
                    count_nxt_s = count_r - 3'd1;
                end else begin
                    count_nxt_s = count_r;
                end
            end else begin
                // Clear on an empty entry backs out of the whole sequence quietly.
                if (count_r != 3'd0) begin
                    entry_nxt_s = 16'h0000;
                    count_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
        end else if (tmr_r == TMR_LAST) begin
            state_nxt_s = ST_IDLE;
            error_nxt_s = 1'b1;
            entry_nxt_s = 16'h0000;
            count_nxt_s = 3'd0;
            tmr_nxt_s   = TMR_ZERO;
        end else begin
            tmr_nxt_s = tmr_r + TMR_W'(1);
        end
    end

    // State, datapath and pulse registers; reset samples set_request so a held button cannot start a change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            entry_r         <= 16'h0000;
            count_r         <= 3'd0;
            buf_r           <= 16'h0000;
            stored_r        <= DEFAULT_PW;
            tmr_r           <= TMR_ZERO;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
            clear_lockout_r <= 1'b0;
            prev_req_r      <= bus.set_request;
        end else begin
            state_r         <= state_nxt_s;
            entry_r         <= entry_nxt_s;
            count_r         <= count_nxt_s;
            buf_r           <= buf_nxt_s;
            stored_r        <= stored_nxt_s;
            tmr_r           <= tmr_nxt_s;
            done_r          <= done_nxt_s;
            error_r         <= error_nxt_s;
            clear_lockout_r <= done_nxt_s;
            prev_req_r      <= bus.set_request;
        end
    end

    assign bus.stored_pw     = stored_r;
    assign bus.entry_digits  = entry_r;
    assign bus.mode          = state_r;
    assign bus.set_done      = done_r;
    assign bus.set_error     = error_r;
    assign bus.clear_lockout = clear_lockout_r;
endmodule

// File: tb/tb_lock_password_setter.sv
// Directed and random stimulus for lock_password_setter against a queue-based model of the change sequence.
module tb_lock_password_setter;
    localparam logic [15:0] DEF_PW = 16'h1234;
    localparam int          TMO    = 8;

    logic clock;
    logic reset;
    lock_password_setter_if bus();

    lock_password_setter #(.DEFAULT_PW(DEF_PW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 authenticate, 2 new, 3 confirm.
    int          m_ph;
    int          m_dq[$];
    logic [15:0] m_spw;
    logic [15:0] m_newpw;
    int          m_idle;
    logic        m_prev;
    logic        m_done;
    logic        m_err;

    function automatic logic [15:0] pack_q();
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < m_dq.size(); i++) r[15-4*i -: 4] = 4'(m_dq[i]);
        return r;
    endfunction

    task automatic model_edge(input logic rst, input logic req, input logic kv, input logic [3:0] kc);
        logic        rise;
        logic [15:0] e;
        if (rst) begin
            m_ph = 0; m_dq.delete(); m_spw = DEF_PW; m_newpw = 16'h0000;
            m_idle = 0; m_prev = req; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        m_done = 1'b0;
        m_err  = 1'b0;
        rise   = req && !m_prev;
        m_prev = req;
        if (m_ph == 0) begin
            if (rise) begin
                m_ph = 1; m_dq.delete(); m_idle = 0;
            end
        end else if (m_dq.size() == 4) begin
            e = pack_q();
            m_dq.delete();
            m_idle = 0;
            if (m_ph == 1) begin
                if (e == m_spw) m_ph = 2;
                else begin m_err = 1'b1; m_ph = 0; end
            end else if (m_ph == 2) begin
                m_newpw = e; m_ph = 3;
            end else begin
                if (e == m_newpw) begin m_spw = m_newpw; m_done = 1'b1; m_ph = 0; end
                else begin m_err = 1'b1; m_ph = 2; end
                m_newpw = 16'h0000;
            end
        end else if (kv && kc >= 4'd1 && kc <= 4'd11) begin
            m_idle = 0;
            if (kc <= 4'd9) m_dq.push_back(int'(kc));
            else if (kc == 4'd10) begin
                if (m_dq.size() > 0) void'(m_dq.pop_back());
            end else begin
                if (m_dq.size() > 0) m_dq.delete();
                else m_ph = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TMO - 1) begin
                m_ph = 0; m_err = 1'b1; m_dq.delete(); m_idle = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic req, input logic kv, input logic [3:0] kc);
        reset           = rst;
        bus.set_request = req;
        bus.key_valid   = kv;
        bus.key_code    = kc;
        @(posedge clock);
        model_edge(rst, req, kv, kc);
        #1;
        chk("stored_pw",     bus.stored_pw,              m_spw);
        chk("entry_digits",  bus.entry_digits,           pack_q());
        chk("mode",          {14'd0, bus.mode},          16'(m_ph));
        chk("set_done",      {15'd0, bus.set_done},      {15'd0, m_done});
        chk("set_error",     {15'd0, bus.set_error},     {15'd0, m_err});
        chk("clear_lockout", {15'd0, bus.clear_lockout}, {15'd0, m_done});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b0, 1'b0, 1'b1, k);
    endtask

    task automatic press();
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    // Four digits followed by the evaluation cycle.
    task automatic type4(input logic [15:0] w);
        for (int i = 0; i < 4; i++) key(w[15-4*i -: 4]);
        idle(1);
    endtask

    logic [15:0] rw;

    initial begin
        reset = 1'b1; bus.set_request = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;
        do_reset();
        chk("reset_stored", bus.stored_pw, 16'h1234);
        chk("reset_mode", {14'd0, bus.mode}, 16'd0);

        // Full change to 5678, checking the 1-cycle evaluation latency.
        press();
        chk("auth_mode", {14'd0, bus.mode}, 16'd1);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("eval_wait_mode", {14'd0, bus.mode}, 16'd1);
        chk("eval_wait_entry", bus.entry_digits, 16'h1234);
        idle(1);
        chk("auth_ok_mode", {14'd0, bus.mode}, 16'd2);
        type4(16'h5678);
        chk("confirm_mode", {14'd0, bus.mode}, 16'd3);
        key(4'd5); key(4'd6); key(4'd7); key(4'd8);
        idle(1);
        chk("commit_done", {15'd0, bus.set_done}, 16'd1);
        chk("commit_clear", {15'd0, bus.clear_lockout}, 16'd1);
        chk("commit_pw", bus.stored_pw, 16'h5678);
        idle(1);
        chk("done_one_cycle", {15'd0, bus.set_done}, 16'd0);

        // Wrong authentication.
        do_reset();
        press();
        type4(16'h1235);
        chk("auth_fail_err", {15'd0, bus.set_error}, 16'd1);
        chk("auth_fail_pw", bus.stored_pw, 16'h1234);

        // Confirm mismatch returns to NEW, then retype.
        press();
        type4(16'h1234);
        type4(16'h9876);
        type4(16'h9875);
        chk("mismatch_err", {15'd0, bus.set_error}, 16'd1);
        chk("mismatch_mode", {14'd0, bus.mode}, 16'd2);
        chk("mismatch_entry", bus.entry_digits, 16'h0000);
        type4(16'h9876);
        type4(16'h9876);
        chk("retype_pw", bus.stored_pw, 16'h9876);

        // Editing keys.
        do_reset();
        press();
        key(4'd1); key(4'd2); key(4'd9); key(4'd10);
        chk("delete_entry", bus.entry_digits, 16'h1200);
        key(4'd3); key(4'd4); idle(1);
        chk("edited_auth", {14'd0, bus.mode}, 16'd2);
        key(4'd5); key(4'd6); key(4'd11);
        chk("clear_entry", bus.entry_digits, 16'h0000);
        chk("clear_mode", {14'd0, bus.mode}, 16'd2);
        key(4'd11);
        chk("abort_mode", {14'd0, bus.mode}, 16'd0);
        chk("abort_noerr", {15'd0, bus.set_error}, 16'd0);
        press();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("fifth_ignored", bus.entry_digits, 16'h0000);
        chk("fifth_mode", {14'd0, bus.mode}, 16'd2);
        key(4'd13);
        idle(1);

        // Timeout, with a key in cycle 6 restarting the count.
        do_reset();
        press();
        key(4'd1);
        idle(5);
        key(4'd2);
        idle(6);
        chk("tmo_restart_mode", {14'd0, bus.mode}, 16'd1);
        idle(1);
        chk("tmo_err", {15'd0, bus.set_error}, 16'd1);
        chk("tmo_mode", {14'd0, bus.mode}, 16'd0);
        chk("tmo_entry", bus.entry_digits, 16'h0000);

        // Reset in CONFIRM with set_request held high through and after reset.
        press(); type4(16'h1234); type4(16'h5678); type4(16'h5678);
        chk("pre_reset_pw", bus.stored_pw, 16'h5678);
        press(); type4(16'h5678); type4(16'h1111);
        key(4'd1); key(4'd1);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        chk("midrst_pw", bus.stored_pw, 16'h1234);
        chk("midrst_mode", {14'd0, bus.mode}, 16'd0);
        chk("midrst_err", {15'd0, bus.set_error}, 16'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
        chk("held_no_start", {14'd0, bus.mode}, 16'd0);
        press();
        chk("repress_start", {14'd0, bus.mode}, 16'd1);

        // Random traffic.
        rw = 16'h1111;
        for (int it = 0; it < 600; it++) begin
            case ($urandom_range(0, 9))
                0: press();
                1, 2: type4(m_spw);
                3: begin
                    if ($urandom_range(0, 1) == 0)
                        rw = {4'($urandom_range(1, 9)), 4'($urandom_range(1, 9)),
                              4'($urandom_range(1, 9)), 4'($urandom_range(1, 9))};
                    type4(rw);
                end
                4: idle($urandom_range(0, 9));
                5: key(4'($urandom_range(0, 15)));
                6: step(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom_range(1, 11)));
                7: if ($urandom_range(0, 30) == 0) do_reset(); else key(4'($urandom_range(10, 11)));
                default: key(4'($urandom_range(1, 9)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lock_password_setter.md
Name: lock_password_setter

Overview:
- Write side of the 4-digit keypad lock. Programs and holds the stored password that the lock's comparator reads.
- Consumes the same decoded key stream as the entry path: digit codes 1-9, delete 10, clear 11.
- Runs an authenticate -> new -> confirm sequence and drives the stored password, an entry display bus and status pulses.
- On a successful change, also pulses a lockout clear to the failure-count logic.

Parameters:
- DEFAULT_PW, 16'h1234, password loaded on reset; nibble [15:12] is digit 1, [3:0] is digit 4; every nibble must be 1-9.
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed in any non-IDLE state before abort (minimum 2).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- set_request  input  1  level from the program button; a rising edge starts a change
- key_valid  input  1  one-cycle strobe qualifying key_code
- key_code  input  4  1-9 = digit, 10 = delete, 11 = clear, any other value is ignored
- stored_pw  output  16  current password, 4 nibbles, to comparator
- entry_digits  output  16  digits typed in the current phase (0 = blank), for 7-seg drivers
- mode  output  2  0 IDLE, 1 AUTH, 2 NEW, 3 CONFIRM
- set_done  output  1  one-cycle pulse when a new password is committed
- set_error  output  1  one-cycle pulse on auth fail, confirm mismatch or timeout
- clear_lockout  output  1  one-cycle pulse, coincident with set_done

Behaviour:
- Reset values: stored_pw=DEFAULT_PW, entry_digits=0, mode=IDLE, set_done=0, set_error=0, clear_lockout=0; digit count, new-password buffer and timeout counter all 0.
- Reset asserted mid-sequence discards the sequence and restores DEFAULT_PW.
- set_request rising edge is detected with a registered previous value.
  - In IDLE, the edge moves to AUTH with the entry cleared.
  - In any other state the edge is ignored.
- Keys are accepted only when key_valid=1 and mode!=IDLE. In IDLE, keys are ignored.
- Digit key:
  - count<4: written into nibble [count] (digit 1 at [15:12]), count+1.
  - count==4: ignored.
- Delete key:
  - count>0: count-1 and that nibble zeroed.
  - count==0: no effect.
- Clear key:
  - count>0: all nibbles zeroed, count=0.
  - count==0: abort to IDLE, no error pulse.
- Evaluation runs on the edge after the cycle in which count reaches 4, so there is a 1-cycle latency from the 4th digit. Keys arriving in that cycle are ignored. The entry is then cleared and count set to 0.
  - AUTH: entry==stored_pw -> NEW. Otherwise set_error and go to IDLE.
  - NEW: entry latched into the new buffer -> CONFIRM.
  - CONFIRM: entry==buffer -> stored_pw<=buffer, set_done and clear_lockout pulse, go to IDLE. Otherwise set_error and return to NEW; the buffer is discarded.
- Timeout:
  - The counter runs in non-IDLE states and resets on each accepted key and on every state change.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, set_error pulse, entry cleared, stored_pw unchanged.
  - In IDLE the counter is held at 0.
- Pulses are registered, high for exactly one cycle, and never set_done and set_error together.
- stored_pw changes only on a CONFIRM match or on reset; it is stable at all other times.

Test Plan:
- Reset, then set_request edge, keys 1,2,3,4 -> mode 1->2 one cycle after the 4th key; keys 5,6,7,8 then 5,6,7,8 -> set_done and clear_lockout high one cycle, stored_pw=16'h5678, mode=0.
- AUTH with 1,2,3,5 -> set_error one cycle, mode=0, stored_pw=16'h1234.
- NEW 9,8,7,6 then CONFIRM 9,8,7,5 -> set_error, mode=2, entry_digits=0; retype 9,8,7,6 twice -> stored_pw=16'h9876.
- In AUTH: 1,2,9, delete, 3,4 -> accepted as 1234. Clear at count 2 -> entry 0, mode unchanged. Clear at count 0 -> mode=0, no set_error. A 5th digit after four while evaluating is ignored.
- TIMEOUT_CYCLES=8: set_request, one digit, then idle 7 cycles -> set_error, mode=0. A key in cycle 6 restarts the count.
- Mid-CONFIRM reset pulse after a prior change to 16'h5678 -> stored_pw=16'h1234, mode=0, all pulses 0; set_request held high across reset generates no start until released and re-pressed.
